cw_time_set_ctrl: RTL

CW_TIME_SET_CTRL -- requirements
Module: cw_time_set_ctrl

---
 rtl/cw_time_set_ctrl_if.sv | 25 ++
 rtl/cw_time_set_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cw_time_set_ctrl_if.sv
// Button/tick inputs and field strobe outputs of the clock time-set controller.
`timescale 1ns/1ps
interface cw_time_set_ctrl_if;
  logic       i_Tick;
  logic       i_Mode;
  logic       i_Up;
  logic       i_Dn;
  logic       i_SecMax;
  logic       i_MinMax;
  logic [2:0] o_Inc;
  logic [2:0] o_Dec;
  logic       o_Setting;
  logic [1:0] o_Field;
  logic       o_Blink;

  modport master (
    output i_Tick, i_Mode, i_Up, i_Dn, i_SecMax, i_MinMax,
    input  o_Inc, o_Dec, o_Setting, o_Field, o_Blink
  );

  modport slave (
    input  i_Tick, i_Mode, i_Up, i_Dn, i_SecMax, i_MinMax,
    output o_Inc, o_Dec, o_Setting, o_Field, o_Blink
  );
endinterface

// File: rtl/cw_time_set_ctrl.sv
// Time-set controller: RUN/SET_HR/SET_MIN/SET_SEC mode FSM, button edge detect,
// hold-to-auto-repeat, idle timeout back to RUN and blink control.
`timescale 1ns/1ps
module cw_time_set_ctrl #(
  parameter int HOLD_CYC      = 8,
  parameter int REPEAT_CYC    = 4,
  parameter int TIMEOUT_TICKS = 10
) (
  input logic             Clk,
  input logic             nRst,
  cw_time_set_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_SEC = 2'b01,
    SET_MIN = 2'b10,
    SET_HR  = 2'b11
  } state_t;

  localparam int CNT_MAX_I = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX_I + 1);
  localparam int IDLE_W    = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [CNT_W-1:0]  HOLD_V    = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0]  REPEAT_V  = CNT_W'(REPEAT_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX_V = CNT_W'(CNT_MAX_I);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT_TICKS);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ZERO = IDLE_W'(0);

  state_t            state_r, state_next_s, state_adv_s;
  logic              mode_d_r, up_d_r, dn_d_r;
  logic              mode_arm_r, up_arm_r, dn_arm_r;
  logic              mode_edge_s, up_edge_s, dn_edge_s, btn_edge_s;
  logic              up_only_s, dn_only_s;
  logic              setting_s, state_change_s, pulse_s;
  logic [2:0]        field_mask_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic              rpt_r, rpt_next_s;
  logic [IDLE_W-1:0] idle_r, idle_next_s;
  logic [2:0]        inc_r, inc_next_s, dec_r, dec_next_s;
  logic              blink_r, blink_next_s;
  logic              setting_dec_s;
  logic [1:0]        field_dec_s;

  // An edge needs the button to have been seen low since reset (arm) and low last cycle.
  assign mode_edge_s = bus.i_Mode & ~mode_d_r & mode_arm_r;
  assign up_edge_s   = bus.i_Up   & ~up_d_r   & up_arm_r;
  assign dn_edge_s   = bus.i_Dn   & ~dn_d_r   & dn_arm_r;
  assign btn_edge_s  = mode_edge_s | up_edge_s | dn_edge_s;
  assign up_only_s   = bus.i_Up & ~bus.i_Dn;
  assign dn_only_s   = bus.i_Dn & ~bus.i_Up;
  assign setting_s   = (state_r != RUN);

  // Button history and arming registers.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      mode_d_r   <= 1'b0;
      up_d_r     <= 1'b0;
      dn_d_r     <= 1'b0;
      mode_arm_r <= 1'b0;
      up_arm_r   <= 1'b0;
      dn_arm_r   <= 1'b0;
    end else begin
      mode_d_r   <= bus.i_Mode;
      up_d_r     <= bus.i_Up;
      dn_d_r     <= bus.i_Dn;
      mode_arm_r <= mode_arm_r | ~bus.i_Mode;
      up_arm_r   <= up_arm_r   | ~bus.i_Up;
      dn_arm_r   <= dn_arm_r   | ~bus.i_Dn;
    end
  end

  // Field selection mask, mode-advance target and direct state decode.
  always_comb begin
    field_mask_s  = 3'b000;
    state_adv_s   = RUN;
    setting_dec_s = 1'b0;
    field_dec_s   = 2'b00;
    case (state_r)
      RUN: begin
        field_mask_s  = 3'b000;
        state_adv_s   = SET_HR;
        setting_dec_s = 1'b0;
        field_dec_s   = 2'b00;
      end
      SET_HR: begin
        field_mask_s  = 3'b100;
        state_adv_s   = SET_MIN;
        setting_dec_s = 1'b1;
        field_dec_s   = 2'b11;
      end
      SET_MIN: begin
        field_mask_s  = 3'b010;
        state_adv_s   = SET_SEC;
        setting_dec_s = 1'b1;
        field_dec_s   = 2'b10;
      end
      SET_SEC: begin
        field_mask_s  = 3'b001;
        state_adv_s   = RUN;
        setting_dec_s = 1'b1;
        field_dec_s   = 2'b01;
      end
      default: begin
        field_mask_s  = 3'b000;
        state_adv_s   = RUN;
        setting_dec_s = 1'b0;
        field_dec_s   = 2'b00;
      end
    endcase
  end

  // Next state: a mode edge wins over the idle timeout.
  always_comb begin
    state_next_s = state_r;
    if (mode_edge_s) begin
      state_next_s = state_adv_s;
    end else if (setting_s && (idle_r == TIMEOUT_V)) begin
      state_next_s = RUN;
    end else begin
      state_next_s = state_r;
    end
  end

  assign state_change_s = (state_next_s != state_r);

  // Hold/repeat counter: cnt_r == 0 means no qualifying press is being tracked.
  always_comb begin
    cnt_next_s = cnt_r;
    rpt_next_s = rpt_r;
    pulse_s    = 1'b0;
    if (!setting_s || state_change_s || !(up_only_s || dn_only_s)) begin
      cnt_next_s = CNT_ZERO;
      rpt_next_s = 1'b0;
    end else if (up_edge_s || dn_edge_s) begin
      cnt_next_s = CNT_ONE;
      rpt_next_s = 1'b0;
      pulse_s    = 1'b1;
    end else if (cnt_r == CNT_ZERO) begin
      cnt_next_s = CNT_ZERO;
    end else if (!rpt_r && (cnt_r == HOLD_V)) begin
      cnt_next_s = CNT_ONE;
      rpt_next_s = 1'b1;
      pulse_s    = 1'b1;
    end else if (rpt_r && (cnt_r == REPEAT_V)) begin
      cnt_next_s = CNT_ONE;
      pulse_s    = 1'b1;
    end else if (cnt_r != CNT_MAX_V) begin
      cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Strobe, idle-counter and blink next values.
  always_comb begin
    inc_next_s   = 3'b000;
    dec_next_s   = 3'b000;
    idle_next_s  = idle_r;
    blink_next_s = blink_r;

    if (!setting_s) begin
      if (bus.i_Tick) begin
        inc_next_s = {bus.i_SecMax & bus.i_MinMax, bus.i_SecMax, 1'b1};
      end else begin
        inc_next_s = 3'b000;
      end
    end else if (pulse_s) begin
      inc_next_s = up_only_s ? field_mask_s : 3'b000;
      dec_next_s = dn_only_s ? field_mask_s : 3'b000;
    end else begin
      inc_next_s = 3'b000;
      dec_next_s = 3'b000;
    end

    if (!setting_s || state_change_s || btn_edge_s) begin
      idle_next_s = IDLE_ZERO;
    end else if (bus.i_Tick && (idle_r != TIMEOUT_V)) begin
      idle_next_s = idle_r + IDLE_ONE;
    end else begin
      idle_next_s = idle_r;
    end

    if (state_next_s == RUN) begin
      blink_next_s = 1'b0;
    end else if (state_change_s) begin
      blink_next_s = 1'b1;
    end else if (bus.i_Tick) begin
      blink_next_s = ~blink_r;
    end else begin
      blink_next_s = blink_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_r <= RUN;
      cnt_r   <= CNT_ZERO;
      rpt_r   <= 1'b0;
      idle_r  <= IDLE_ZERO;
      inc_r   <= 3'b000;
      dec_r   <= 3'b000;
      blink_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      rpt_r   <= rpt_next_s;
      idle_r  <= idle_next_s;
      inc_r   <= inc_next_s;
      dec_r   <= dec_next_s;
      blink_r <= blink_next_s;
    end
  end

  assign bus.o_Inc     = inc_r;
  assign bus.o_Dec     = dec_r;
  assign bus.o_Blink   = blink_r;
  assign bus.o_Setting = setting_dec_s;
  assign bus.o_Field   = field_dec_s;

endmodule
